oled_spi_arbiter: RTL and testbench
===================================

OLED_SPI_ARBITER -- requirements
Module: oled_spi_arbiter

Interface
REQ-001 Parameter c_clk_div, default 1, SPI half-period in clk cycles (legal range >=1).
REQ-002 Parameter c_gap, default 2, minimum clk cycles spi_csn is held high between bursts (legal range >=1).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command byte offered.
REQ-006 cmd_data  in  8  command byte, sent with spi_dc=0.
REQ-007 cmd_ready  out  1  command byte accepted this cycle when cmd_valid=1.
REQ-008 pix_valid  in  1  pixel byte offered.
REQ-009 pix_data  in  8  pixel byte, sent with spi_dc=1.
REQ-010 pix_last  in  1  qualifies pix_data as the final byte of a frame.
REQ-011 pix_ready  out  1  pixel byte accepted this cycle when pix_valid=1.
REQ-012 spi_csn, spi_clk, spi_mosi, spi_dc  out  1 each  OLED SPI bus, all registered.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 frame_done  out  1  one-cycle pulse on the last clk cycle of a pix_last byte.

Function
REQ-015 States: IDLE, CMD, PIX, STALL, GAP.
REQ-016 IDLE arbitration: cmd_ready=cmd_valid; pix_ready=pix_valid & ~cmd_valid; both ready signals SHALL be 0 in every other case; when both valid, command wins.
REQ-017 An accepted byte is loaded on accept cycle T; from T+1, spi_csn=0, spi_dc set per channel, and mosi=bit7.
REQ-018 Bit timing: MSB first; each bit is c_clk_div cycles with spi_clk=0, then c_clk_div cycles with spi_clk=1; mosi changes only while spi_clk=0; one byte occupies cycles T+1..T+16*c_clk_div.
REQ-019 The granted channel's ready SHALL be high on the last cycle of each byte; an accept there starts the next byte with no gap (back-to-back, two bytes = 32*c_clk_div cycles).
REQ-020 CMD: when cmd_valid=0 at byte end, go to GAP; pixel requests are ignored until then.
REQ-021 PIX: the grant is locked until the pix_last byte completes; commands wait (no tearing); after pix_last go to GAP and pulse frame_done.
REQ-022 PIX underrun (pix_valid=0 at byte end, not last): go to STALL, hold spi_clk=0 and spi_csn=0, keep pix_ready=1; accept at cycle S gives bit7 at S+1.
REQ-023 GAP: spi_csn=1, spi_clk=0 for exactly c_gap cycles, then IDLE; no ready asserted during GAP.
REQ-024 Counters: bit index 3 bits, divider ceil(log2(c_clk_div)) bits, gap counter ceil(log2(c_gap+1)) bits; no wrap beyond terminal count.

Reset
REQ-025 While reset=1, on the next edge: spi_csn=1, spi_clk=0, spi_mosi=0, spi_dc=0, cmd_ready=0, pix_ready=0, busy=0, frame_done=0, state=IDLE.
REQ-026 Reset mid-byte or mid-frame: abort at once, discard the partial byte and the frame lock; no GAP is enforced afterwards.

Verification (c_clk_div=1, c_gap=2)
REQ-027 Drive cmd_valid=1, cmd_data=0xA5 for one cycle -> spi_dc=0, mosi 1,0,1,0,0,1,0,1 over 16 cycles, 8 rising spi_clk edges, then spi_csn=1 for 2 cycles, busy=0.
REQ-028 Raise cmd_valid and pix_valid in the same IDLE cycle -> cmd_ready=1, pix_ready=0; the command byte is sent first, and the pixel byte starts after the 2-cycle gap.
REQ-029 Raise cmd_valid during the 2nd of 3 pixel bytes (last flagged) -> the command waits; frame_done pulses once; the command byte starts 2 gap cycles later.
REQ-030 Drop pix_valid for 5 cycles between pixel bytes -> spi_clk=0 and spi_csn=0 for 5 cycles, then a correct resume with no lost or duplicated byte.
REQ-031 Assert reset at bit 4 of a pixel byte -> next cycle spi_csn=1, spi_clk=0, busy=0; the next cmd byte sends normally.
REQ-032 Stream 0x12 and 0x34 back-to-back on pix -> 32 contiguous cycles with spi_csn low and spi_dc=1, no stall cycle.

Source files
------------

// File: rtl/oled_spi_arbiter_if.sv
// Command/pixel byte handshake bundle between a display driver and oled_spi_arbiter.
// The master offers bytes; the arbiter (slave) returns per-channel ready.
interface oled_spi_arbiter_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_last;
  logic       pix_ready;

  modport master (
    output cmd_valid, cmd_data, pix_valid, pix_data, pix_last,
    input  cmd_ready, pix_ready
  );

  modport slave (
    input  cmd_valid, cmd_data, pix_valid, pix_data, pix_last,
    output cmd_ready, pix_ready
  );
endinterface

// File: rtl/oled_spi_arbiter.sv
// Arbitrates a command byte stream and a pixel byte stream onto one OLED SPI bus.
// Pixel frames lock the bus until pix_last; bursts are separated by a csn-high gap.
module oled_spi_arbiter #(
  parameter int unsigned c_clk_div = 32'd1,
  parameter int unsigned c_gap     = 32'd2
) (
  input  logic                      clk,
  input  logic                      reset,
  oled_spi_arbiter_if.slave         host,
  output logic                      spi_csn,
  output logic                      spi_clk,
  output logic                      spi_mosi,
  output logic                      spi_dc,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int unsigned c_div_w = (c_clk_div > 32'd1) ? $clog2(c_clk_div) : 32'd1;
  localparam int unsigned c_gap_w = $clog2(c_gap + 32'd1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_clk_div - 32'd1);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(32'd1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(c_gap - 32'd1);
  localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(32'd1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_PIX   = 3'd2,
    ST_STALL = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [7:0]           data_r;
  logic                 last_r;
  logic [2:0]           bit_idx_r;
  logic [c_div_w-1:0]   div_cnt_r;
  logic [c_gap_w-1:0]   gap_cnt_r;
  logic                 spi_csn_r;
  logic                 spi_clk_r;
  logic                 spi_mosi_r;
  logic                 spi_dc_r;

  logic                 sending_s;
  logic                 tick_s;
  logic                 byte_end_s;
  logic                 cmd_ready_s;
  logic                 pix_ready_s;
  logic                 frame_done_s;
  logic                 load_cmd_s;
  logic                 load_pix_s;

  assign sending_s  = (state_r == ST_CMD) || (state_r == ST_PIX);
  assign tick_s     = (div_cnt_r == c_div_last);
  // Last cycle of a byte: bit 0 is in its spi_clk-high half and the divider expires.
  assign byte_end_s = sending_s && tick_s && spi_clk_r && (bit_idx_r == 3'd0);
  assign load_cmd_s = host.cmd_valid & cmd_ready_s;
  assign load_pix_s = host.pix_valid & pix_ready_s;

  assign host.cmd_ready = cmd_ready_s & ~reset;
  assign host.pix_ready = pix_ready_s & ~reset;
  assign frame_done     = frame_done_s & ~reset;
  assign busy           = (state_r != ST_IDLE);
  assign spi_csn        = spi_csn_r;
  assign spi_clk        = spi_clk_r;
  assign spi_mosi       = spi_mosi_r;
  assign spi_dc         = spi_dc_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_cmd_s)      state_s = ST_CMD;
        else if (load_pix_s) state_s = ST_PIX;
        else                 state_s = ST_IDLE;
      end
      ST_CMD: begin
        if (byte_end_s) state_s = load_cmd_s ? ST_CMD : ST_GAP;
        else            state_s = ST_CMD;
      end
      ST_PIX: begin
        if (!byte_end_s)     state_s = ST_PIX;
        else if (last_r)     state_s = ST_GAP;
        else if (load_pix_s) state_s = ST_PIX;
        else                 state_s = ST_STALL;
      end
      ST_STALL: state_s = load_pix_s ? ST_PIX : ST_STALL;
      ST_GAP:   state_s = (gap_cnt_r == c_gap_last) ? ST_IDLE : ST_GAP;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Grant and frame outputs per state.
  always_comb begin
    cmd_ready_s  = 1'b0;
    pix_ready_s  = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = host.cmd_valid;
        pix_ready_s = host.pix_valid & ~host.cmd_valid;
      end
      ST_CMD:   cmd_ready_s = byte_end_s;
      ST_PIX: begin
        pix_ready_s  = byte_end_s & ~last_r;
        frame_done_s = byte_end_s & last_r;
      end
      ST_STALL: pix_ready_s = 1'b1;
      ST_GAP:   cmd_ready_s = 1'b0;
      default:  cmd_ready_s = 1'b0;
    endcase
  end

  // Shift datapath, bit/divider/gap counters and registered SPI pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r     <= 8'h00;
      last_r     <= 1'b0;
      bit_idx_r  <= 3'd0;
      div_cnt_r  <= '0;
      gap_cnt_r  <= '0;
      spi_csn_r  <= 1'b1;
      spi_clk_r  <= 1'b0;
      spi_mosi_r <= 1'b0;
      spi_dc_r   <= 1'b0;
    end else if (load_cmd_s || load_pix_s) begin
      data_r     <= load_cmd_s ? host.cmd_data : host.pix_data;
      last_r     <= load_pix_s & host.pix_last;
      spi_dc_r   <= load_pix_s;
      spi_mosi_r <= load_cmd_s ? host.cmd_data[7] : host.pix_data[7];
      spi_csn_r  <= 1'b0;
      spi_clk_r  <= 1'b0;
      bit_idx_r  <= 3'd7;
      div_cnt_r  <= '0;
      gap_cnt_r  <= '0;
    end else begin
      case (state_r)
        ST_CMD, ST_PIX: begin
          if (byte_end_s) begin
            // Stall keeps the device selected; everything else releases it.
            spi_csn_r <= (state_s != ST_STALL);
            spi_clk_r <= 1'b0;
            div_cnt_r <= '0;
          end else if (tick_s) begin
            div_cnt_r <= '0;
            if (!spi_clk_r) begin
              spi_clk_r <= 1'b1;
            end else begin
              spi_clk_r  <= 1'b0;
              bit_idx_r  <= bit_idx_r - 3'd1;
              spi_mosi_r <= data_r[bit_idx_r - 3'd1];
            end
          end else begin
            div_cnt_r <= div_cnt_r + c_div_one;
          end
        end
        ST_STALL: begin
          spi_csn_r <= 1'b0;
          spi_clk_r <= 1'b0;
        end
        ST_GAP: begin
          spi_csn_r <= 1'b1;
          spi_clk_r <= 1'b0;
          gap_cnt_r <= (gap_cnt_r == c_gap_last) ? '0 : gap_cnt_r + c_gap_one;
        end
        ST_IDLE: begin
          spi_csn_r <= 1'b1;
          spi_clk_r <= 1'b0;
          gap_cnt_r <= '0;
        end
        default: begin
          spi_csn_r <= 1'b1;
          spi_clk_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Scoreboard bench for oled_spi_arbiter: accepted bytes are queued as {dc,data}
// and compared with bytes reassembled from the SPI pins.
module tb_oled_spi_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic spi_csn, spi_clk, spi_mosi, spi_dc, busy, frame_done;

  oled_spi_arbiter_if bus();

  oled_spi_arbiter #(.c_clk_div(1), .c_gap(2)) dut (
    .clk(clk), .reset(reset), .host(bus.slave),
    .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cmd_byte(input logic [7:0] d);
    bit done = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      #2;
      if (bus.cmd_ready) begin
        sb.push_back({1'b0, d});
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic pix_byte(input logic [7:0] d, input logic last);
    bit done = 1'b0;
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_last  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      #2;
      if (bus.pix_ready) begin
        sb.push_back({1'b1, d});
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("pix_accept_timeout", 0, 1);
  endtask

  task automatic cmd_idle;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pix_idle;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  task automatic wait_idle;
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy && spi_csn && sb.size() == 0) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Bus monitor: reassembles bytes on spi_clk rising edges and measures run lengths.
  int run = 0, hi = 0, rises = 0, gapc = 0, nbits = 0, fd_cnt = 0;
  int last_run = 0, last_hi = 0, last_rises = 0, last_gap = 0;
  bit run_dc = 1'b1, last_dc = 1'b0;
  logic prev_csn = 1'b1, prev_sclk = 1'b0;
  logic [7:0] rx = 8'h00;
  logic [8:0] exp_b;

  always @(negedge clk) begin
    if (reset) begin
      nbits = 0; prev_csn = 1'b1; prev_sclk = 1'b0;
      run = 0; hi = 0; rises = 0; gapc = 0; run_dc = 1'b1;
    end else begin
      if (frame_done) fd_cnt++;
      if (!spi_csn) begin
        if (prev_csn) begin last_hi = hi; hi = 0; end
        run++;
        if (!spi_dc) run_dc = 1'b0;
        if (spi_clk && !prev_sclk) begin
          rises++;
          rx = {rx[6:0], spi_mosi};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            if (sb.size() == 0) begin
              check("unexpected_byte", {23'd0, spi_dc, rx}, 32'h1ff);
            end else begin
              exp_b = sb.pop_front();
              check("spi_byte", {23'd0, spi_dc, rx}, {23'd0, exp_b});
            end
          end
        end
      end else begin
        if (!prev_csn) begin
          last_run = run; last_rises = rises; last_dc = run_dc;
          run = 0; rises = 0; run_dc = 1'b1;
        end
        hi++;
      end
      if (busy && spi_csn) gapc++;
      else if (gapc != 0) begin last_gap = gapc; gapc = 0; end
      prev_csn = spi_csn;
      prev_sclk = spi_clk;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation watchdog expired");
  end

  int fd0;
  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_data = 8'h00;
    bus.pix_valid = 1'b0; bus.pix_data = 8'h00; bus.pix_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_csn", spi_csn, 1);
    check("rst_sclk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_dc", spi_dc, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_pix_ready", bus.pix_ready, 0);
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single command byte 0xA5.
    cmd_byte(8'hA5);
    cmd_idle();
    wait_idle();
    check("a5_csn_low_cycles", last_run, 16);
    check("a5_sclk_rises", last_rises, 8);
    check("a5_gap_cycles", last_gap, 2);
    check("a5_busy_after", busy, 0);

    // Simultaneous requests: command wins, pixel follows after gap.
    fd0 = fd_cnt;
    fork
      begin cmd_byte(8'h3C); cmd_idle(); end
      begin pix_byte(8'hC3, 1'b1); pix_idle(); end
      begin
        @(negedge clk); #2;
        check("arb_cmd_ready", bus.cmd_ready, 1);
        check("arb_pix_ready", bus.pix_ready, 0);
      end
    join
    wait_idle();
    check("arb_csn_high_before_pix", last_hi, 3);
    check("arb_pix_dc", last_dc, 1);
    check("arb_frame_done", fd_cnt - fd0, 1);

    // Command raised during a 3-byte frame must wait for the frame to end.
    fd0 = fd_cnt;
    fork
      begin
        pix_byte(8'h11, 1'b0); pix_byte(8'h22, 1'b0); pix_byte(8'h33, 1'b1);
        pix_idle();
      end
      begin
        repeat (20) @(negedge clk);
        cmd_byte(8'h5A);
        check("lock_frame_done_before_cmd", fd_cnt - fd0, 1);
        cmd_idle();
      end
    join
    wait_idle();
    check("lock_frame_done_once", fd_cnt - fd0, 1);
    check("lock_csn_high_before_cmd", last_hi, 3);

    // Underrun: five-cycle stall between two pixel bytes.
    fd0 = fd_cnt;
    pix_byte(8'h55, 1'b0);
    pix_idle();
    repeat (19) @(negedge clk);
    pix_byte(8'hAA, 1'b1);
    pix_idle();
    wait_idle();
    check("stall_csn_low_cycles", last_run, 37);
    check("stall_sclk_rises", last_rises, 16);
    check("stall_frame_done", fd_cnt - fd0, 1);

    // Back-to-back pixel bytes: no stall cycles.
    fd0 = fd_cnt;
    pix_byte(8'h12, 1'b0);
    pix_byte(8'h34, 1'b1);
    pix_idle();
    wait_idle();
    check("b2b_csn_low_cycles", last_run, 32);
    check("b2b_dc_all_high", last_dc, 1);
    check("b2b_frame_done", fd_cnt - fd0, 1);

    // Reset in the middle of bit 4 of a pixel byte.
    pix_byte(8'h96, 1'b0);
    pix_idle();
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_csn", spi_csn, 1);
    check("mid_rst_sclk", spi_clk, 0);
    check("mid_rst_busy", busy, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    cmd_byte(8'h81);
    cmd_idle();
    wait_idle();
    check("post_rst_sclk_rises", last_rises, 8);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
